// File: rtl/expr_checker.sv
// Streaming syntax checker for arithmetic expressions with multi-digit operands,
// + - * / operators and bounded parenthesis nesting; reports first error position.
module expr_checker #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 3,
    parameter int LEN_W      = 8,
    localparam int DEP_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             out,
    output logic             err,
    output logic [LEN_W-1:0] err_pos,
    output logic [DEP_W-1:0] depth,
    output logic [LEN_W-1:0] len
);

    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DCNT_W-1:0] MAX_DIG_C = DCNT_W'(MAX_DIGITS);
    localparam logic [DEP_W-1:0]  MAX_DEP_C = DEP_W'(MAX_DEPTH);

    localparam logic [1:0] S_OPND  = 2'd0;
    localparam logic [1:0] S_NUM   = 2'd1;
    localparam logic [1:0] S_CLOSE = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  err_pos_q, err_pos_d;
    logic              err_q, err_d;
    logic              out_q, out_d;

    logic is_dig, is_op, is_lp, is_rp;

    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_op  = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
        is_lp  = (in == 8'h28);
        is_rp  = (in == 8'h29);
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        depth_d   = depth_q;
        len_d     = len_q;
        err_pos_d = err_pos_q;
        err_d     = err_q;
        if (in_valid) begin
            if (len_q != {LEN_W{1'b1}})
                len_d = len_q + 1'b1;
            case (state_q)
                S_OPND: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = DCNT_W'(1);
                    end else if (is_lp && depth_q < MAX_DEP_C) begin
                        depth_d = depth_q + 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_dig && dcnt_q < MAX_DIG_C) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end else if (is_op) begin
                        state_d = S_OPND;
                        dcnt_d  = '0;
                    end else if (is_rp && depth_q != '0) begin
                        state_d = S_CLOSE;
                        dcnt_d  = '0;
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CLOSE: begin
                    if (is_op) begin
                        state_d = S_OPND;
                    end else if (is_rp && depth_q != '0) begin
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_ERR;
            endcase
            // Latch the position only on the transition into the error state.
            if (state_d == S_ERR && state_q != S_ERR) begin
                err_d     = 1'b1;
                err_pos_d = len_q;
            end
        end
        out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0) && !err_d;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_OPND;
            dcnt_q    <= '0;
            depth_q   <= '0;
            len_q     <= '0;
            err_pos_q <= '0;
            err_q     <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            depth_q   <= depth_d;
            len_q     <= len_d;
            err_pos_q <= err_pos_d;
            err_q     <= err_d;
            out_q     <= out_d;
        end
    end

    assign out     = out_q;
    assign err     = err_q;
    assign err_pos = err_pos_q;
    assign depth   = depth_q;
    assign len     = len_q;

endmodule

// File: tb/tb_expr_checker.sv
// Directed-vector bench for expr_checker with default parameters
// (MAX_DIGITS=4, MAX_DEPTH=3, LEN_W=8).
module tb_expr_checker;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;
    logic       out, err;
    logic [7:0] err_pos, len;
    logic [1:0] depth;

    int n_checks = 0;
    int n_errors = 0;

    expr_checker dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .err      (err),
        .err_pos  (err_pos),
        .depth    (depth),
        .len      (len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp1 [7];
        logic exp2 [9];
        logic [1:0] dep2 [9];
        string s1, s2;
        exp1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dep2 = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        s1 = "12+3*45";
        s2 = "(1+(2))*3";

        // Reset state
        do_clr();
        check("rst_out", 32'(out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_pos", 32'(err_pos), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_len", 32'(len), 32'd0);

        // 1: plain expression
        for (int i = 0; i < 7; i++) begin
            send(s1[i]);
            check($sformatf("t1_out%0d", i), 32'(out), 32'(exp1[i]));
        end
        check("t1_err", 32'(err), 32'd0);
        check("t1_len", 32'(len), 32'd7);

        // 2: nesting; complete after the outer ')' and again after '3'
        do_clr();
        for (int i = 0; i < 9; i++) begin
            send(s2[i]);
            check($sformatf("t2_out%0d", i), 32'(out), 32'(exp2[i]));
            check($sformatf("t2_dep%0d", i), 32'(depth), 32'(dep2[i]));
        end
        check("t2_err", 32'(err), 32'd0);

        // 3: operand too long
        do_clr();
        send_str("1234");
        check("t3_out4dig", 32'(out), 32'd1);
        send("5");
        check("t3_err", 32'(err), 32'd1);
        check("t3_err_pos", 32'(err_pos), 32'd4);
        check("t3_out", 32'(out), 32'd0);
        send_str("+6");
        check("t3_err_sticky", 32'(err), 32'd1);
        check("t3_err_pos_hold", 32'(err_pos), 32'd4);
        check("t3_len", 32'(len), 32'd7);

        // 4: nesting overflow, then ')' at depth 0
        do_clr();
        send_str("(((");
        check("t4_depth3", 32'(depth), 32'd3);
        check("t4_noerr", 32'(err), 32'd0);
        send("(");
        check("t4_err", 32'(err), 32'd1);
        check("t4_err_pos", 32'(err_pos), 32'd3);
        send("1");
        check("t4_depth_frozen", 32'(depth), 32'd3);
        do_clr();
        send_str("1)");
        check("t4b_err", 32'(err), 32'd1);
        check("t4b_err_pos", 32'(err_pos), 32'd1);

        // 5: in_valid gap
        do_clr();
        send_str("1+");
        check("t5_out_pre", 32'(out), 32'd0);
        idle(3);
        check("t5_out_gap", 32'(out), 32'd0);
        check("t5_len_gap", 32'(len), 32'd2);
        send("2");
        check("t5_out", 32'(out), 32'd1);
        check("t5_len", 32'(len), 32'd3);

        // 6: illegal char, then clr with in_valid high
        do_clr();
        send_str("7+a");
        check("t6_err", 32'(err), 32'd1);
        check("t6_err_pos", 32'(err_pos), 32'd2);
        @(negedge clk);
        clr = 1'b1;
        in = "9";
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_err", 32'(err), 32'd0);
        check("t6_clr_pos", 32'(err_pos), 32'd0);
        check("t6_clr_len", 32'(len), 32'd0);
        check("t6_clr_out", 32'(out), 32'd0);
        send("9");
        check("t6_out", 32'(out), 32'd1);
        check("t6_len", 32'(len), 32'd1);

        // Empty parens, leading operator, division, leading zeros
        do_clr();
        send_str("()");
        check("t7_paren_err_pos", 32'(err_pos), 32'd1);
        do_clr();
        send("-");
        check("t7_unary_err", 32'(err), 32'd1);
        check("t7_unary_pos", 32'(err_pos), 32'd0);
        do_clr();
        send_str("007/2");
        check("t7_div_out", 32'(out), 32'd1);
        check("t7_div_err", 32'(err), 32'd0);

        // len saturation
        do_clr();
        for (int i = 0; i < 260; i++) send("x");
        check("t8_len_sat", 32'(len), 32'd255);
        check("t8_err_pos", 32'(err_pos), 32'd0);
        check("t8_err", 32'(err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
